// File: rtl/pong_match_ctrl_if.sv
// pong_match_ctrl_if
//   Signal bundle between the match controller, the board inputs and the
//   ball/paddle datapath. Clock and reset are deliberately kept outside the
//   bundle and travel as plain ports.
//
//   Signals:
//     frame_tick   one-cycle pulse per video frame
//     serve        serve key level (already synchronised)
//     miss_left    ball passed the left edge (right player scores)
//     miss_right   ball passed the right edge (left player scores)
//     ball_run     ball datapath advances while high
//     ball_load    one-cycle pulse: recentre the ball
//     serve_dir    direction of next serve, 0 = left, 1 = right
//     left_score   left player score, binary
//     right_score  right player score, binary
//     game_over    high while a finished match is displayed
//     winner       0 = left, 1 = right; valid while game_over
//
//   Modports:
//     slave   - the match controller (consumes inputs, drives status)
//     master  - the surrounding board/datapath (drives inputs)
interface pong_match_ctrl_if;
  logic       frame_tick;
  logic       serve;
  logic       miss_left;
  logic       miss_right;
  logic       ball_run;
  logic       ball_load;
  logic       serve_dir;
  logic [3:0] left_score;
  logic [3:0] right_score;
  logic       game_over;
  logic       winner;

  modport slave (
    input  frame_tick, serve, miss_left, miss_right,
    output ball_run, ball_load, serve_dir, left_score, right_score,
           game_over, winner
  );

  modport master (
    output frame_tick, serve, miss_left, miss_right,
    input  ball_run, ball_load, serve_dir, left_score, right_score,
           game_over, winner
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl
//   Match-sequencing FSM for the Pong datapath. Decides when the ball is
//   held, recentred or running, keeps both scores and detects end of match.
//
//   Ports:
//     CLOCK_50  system clock, all state changes on the rising edge
//     reset     synchronous active-high reset
//     bus       pong_match_ctrl_if.slave (frame_tick, serve, miss_left,
//               miss_right in; ball_run, ball_load, serve_dir, left_score,
//               right_score, game_over, winner out)
//
//   Parameters:
//     WIN_SCORE          points needed to win (1..9)
//     PAUSE_FRAMES       frame ticks spent in the post-point pause
//     AUTO_SERVE_FRAMES  frame ticks in SERVE_WAIT before an automatic serve
//
//   Optional feature macro: PONG_AUTO_SERVE_EN
//     Defined   - SERVE_WAIT counts frame ticks and serves by itself after
//                 AUTO_SERVE_FRAMES ticks unless a real serve comes first.
//     Undefined - SERVE_WAIT waits indefinitely for a serve key edge.
//
//   All outputs are registered.
module pong_match_ctrl #(
  parameter int WIN_SCORE         = 9,
  parameter int PAUSE_FRAMES      = 60,
  parameter int AUTO_SERVE_FRAMES = 180
) (
  input logic              CLOCK_50,
  input logic              reset,
  pong_match_ctrl_if.slave bus
);

  localparam int MAX_FRAMES = (PAUSE_FRAMES > AUTO_SERVE_FRAMES) ?
                              PAUSE_FRAMES : AUTO_SERVE_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  typedef enum logic [1:0] {
    SERVE_WAIT  = 2'd0,
    RALLY       = 2'd1,
    POINT_PAUSE = 2'd2,
    GAME_OVER   = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic               serve_d_reg;
  logic               ball_run_reg, ball_run_next;
  logic               ball_load_reg, ball_load_next;
  logic               serve_dir_reg, serve_dir_next;
  logic [3:0]         left_score_reg, left_score_next;
  logic [3:0]         right_score_reg, right_score_next;
  logic               game_over_reg, game_over_next;
  logic               winner_reg, winner_next;
  logic [CNT_W-1:0]   pause_cnt_reg, pause_cnt_next;
`ifdef PONG_AUTO_SERVE_EN
  logic [CNT_W-1:0]   auto_cnt_reg, auto_cnt_next;
`endif

  logic serve_evt;
  logic auto_fire;
  logic [3:0]       left_inc;
  logic [3:0]       right_inc;
  logic [CNT_W-1:0] pause_inc;

  // serve_d resets to 1 so a key held through reset never counts as an edge.
  assign serve_evt = bus.serve & ~serve_d_reg;
  assign left_inc  = left_score_reg + 4'd1;
  assign right_inc = right_score_reg + 4'd1;
  assign pause_inc = pause_cnt_reg + CNT_W'(1);

  // Auto-serve trigger. The counter is held at zero outside SERVE_WAIT, which
  // makes it start from zero on every entry to SERVE_WAIT.
`ifdef PONG_AUTO_SERVE_EN
  always_comb begin
    auto_cnt_next = '0;
    auto_fire     = 1'b0;
    if (state_reg == SERVE_WAIT) begin
      auto_cnt_next = auto_cnt_reg;
      if (bus.frame_tick) begin
        auto_cnt_next = auto_cnt_reg + CNT_W'(1);
        if (auto_cnt_reg + CNT_W'(1) == CNT_W'(AUTO_SERVE_FRAMES)) begin
          auto_fire = 1'b1;
        end
      end
    end
  end
`else
  assign auto_fire = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    ball_run_next    = ball_run_reg;
    ball_load_next   = 1'b0;          // pulse output, high for one cycle only
    serve_dir_next   = serve_dir_reg;
    left_score_next  = left_score_reg;
    right_score_next = right_score_reg;
    game_over_next   = game_over_reg;
    winner_next      = winner_reg;
    pause_cnt_next   = pause_cnt_reg;

    case (state_reg)
      SERVE_WAIT: begin
        ball_run_next = 1'b0;
        if (serve_evt || auto_fire) begin
          state_next    = RALLY;
          ball_run_next = 1'b1;
        end
      end

      RALLY: begin
        ball_run_next = 1'b1;
        // miss_left wins if both edges are reported in the same cycle.
        if (bus.miss_left) begin
          ball_run_next    = 1'b0;
          serve_dir_next   = 1'b0;
          right_score_next = right_inc;
          if (right_inc == 4'(WIN_SCORE)) begin
            state_next     = GAME_OVER;
            game_over_next = 1'b1;
            winner_next    = 1'b1;
          end else begin
            state_next     = POINT_PAUSE;
            pause_cnt_next = '0;
          end
        end else if (bus.miss_right) begin
          ball_run_next   = 1'b0;
          serve_dir_next  = 1'b1;
          left_score_next = left_inc;
          if (left_inc == 4'(WIN_SCORE)) begin
            state_next     = GAME_OVER;
            game_over_next = 1'b1;
            winner_next    = 1'b0;
          end else begin
            state_next     = POINT_PAUSE;
            pause_cnt_next = '0;
          end
        end
      end

      POINT_PAUSE: begin
        ball_run_next = 1'b0;
        if (bus.frame_tick) begin
          pause_cnt_next = pause_inc;
          if (pause_inc == CNT_W'(PAUSE_FRAMES)) begin
            state_next     = SERVE_WAIT;
            ball_load_next = 1'b1;
          end
        end
      end

      GAME_OVER: begin
        ball_run_next  = 1'b0;
        game_over_next = 1'b1;
        if (serve_evt) begin
          state_next       = SERVE_WAIT;
          left_score_next  = '0;
          right_score_next = '0;
          game_over_next   = 1'b0;
          serve_dir_next   = ~winner_reg;   // loser gets the serve
          ball_load_next   = 1'b1;
        end
      end

      default: begin
        state_next = SERVE_WAIT;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg       <= SERVE_WAIT;
      serve_d_reg     <= 1'b1;
      ball_run_reg    <= 1'b0;
      ball_load_reg   <= 1'b0;
      serve_dir_reg   <= 1'b1;
      left_score_reg  <= '0;
      right_score_reg <= '0;
      game_over_reg   <= 1'b0;
      winner_reg      <= 1'b0;
      pause_cnt_reg   <= '0;
`ifdef PONG_AUTO_SERVE_EN
      auto_cnt_reg    <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      serve_d_reg     <= bus.serve;
      ball_run_reg    <= ball_run_next;
      ball_load_reg   <= ball_load_next;
      serve_dir_reg   <= serve_dir_next;
      left_score_reg  <= left_score_next;
      right_score_reg <= right_score_next;
      game_over_reg   <= game_over_next;
      winner_reg      <= winner_next;
      pause_cnt_reg   <= pause_cnt_next;
`ifdef PONG_AUTO_SERVE_EN
      auto_cnt_reg    <= auto_cnt_next;
`endif
    end
  end

  assign bus.ball_run    = ball_run_reg;
  assign bus.ball_load   = ball_load_reg;
  assign bus.serve_dir   = serve_dir_reg;
  assign bus.left_score  = left_score_reg;
  assign bus.right_score = right_score_reg;
  assign bus.game_over   = game_over_reg;
  assign bus.winner      = winner_reg;

endmodule
